id_ex_hazard_ctrl: RTL and testbench
====================================

ID_EX_HAZARD_CTRL -- requirements
Module: id_ex_hazard_ctrl

Interface
REQ-001 Parameter: LOAD_STALL, default 1, load-use stall length in cycles, legal range 1..3.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Control  in  10  ID-stage decoder word: [9] Saltoincond, [8] RegDest, [7] FuenteALU, [6] MemaReg, [5] EscrReg, [4] LeerMem, [3] EscrMem, [2] SaltoCond, [1:0] ALUOp.
REQ-005 id_rs  in  5  rs field of ID instruction.
REQ-006 id_rt  in  5  rt field of ID instruction.
REQ-007 id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-008 br_taken  in  1  conditional branch resolved taken in MEM (SaltoCond & zero), one-cycle pulse.
REQ-009 Controls1  out  10  registered ID/EX control word, feeds the EX/MEM control register.
REQ-010 ex_rt  out  5  registered rt of the EX-stage instruction.
REQ-011 PCWrite  out  1  PC update enable.
REQ-012 IFIDWrite  out  1  IF/ID register load enable.
REQ-013 IFIDFlush  out  1  clear IF/ID to NOP.
REQ-014 EXMEMFlush  out  1  clear EX/MEM control word.
REQ-015 stall_count  out  16  saturating count of load-use stall cycles.
REQ-016 flush_count  out  16  saturating count of taken-branch flushes.

Function
REQ-017 hz SHALL be Controls1[4] & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)); evaluated only in state RUN.
REQ-018 FSM states SHALL be RUN and STALL, plus down-counter cnt (2 bits).
REQ-019 Priority SHALL be rst > br_taken > stall (RUN&hz, or STALL) > jump > normal.
REQ-020 br_taken: IFIDFlush=1, EXMEMFlush=1, PCWrite=1, IFIDWrite=1; next edge Controls1=0, ex_rt=0, state=RUN, cnt=0; flush_count+1; no stall counted.
REQ-021 Stall cycle: PCWrite=0, IFIDWrite=0, flushes 0; next edge Controls1=0, ex_rt=0 (bubble); stall_count+1.
REQ-022 RUN&hz: if LOAD_STALL==1 stay RUN, else go STALL with cnt=LOAD_STALL-2.
REQ-023 STALL: if cnt==0 go RUN, else cnt-1; total stall cycles per hazard SHALL equal LOAD_STALL.
REQ-024 Jump (Control[9] in RUN, no stall, no br_taken): IFIDFlush=1, EXMEMFlush=0, PCWrite=1, IFIDWrite=1; Controls1<=Control.
REQ-025 Normal: PCWrite=1, IFIDWrite=1, flushes 0; Controls1<=Control, ex_rt<=id_rt.
REQ-026 PCWrite, IFIDWrite, IFIDFlush, EXMEMFlush SHALL be combinational from registered state and current inputs; zero-cycle latency.
REQ-027 Controls1 and ex_rt SHALL have one-cycle latency from Control/id_rt.
REQ-028 Counters SHALL saturate at 0xFFFF, never wrap.

Reset
REQ-029 At edge with rst=1: Controls1=0, ex_rt=0, state=RUN, cnt=0, stall_count=0, flush_count=0.
REQ-030 While rst=1: PCWrite=0, IFIDWrite=0, IFIDFlush=0, EXMEMFlush=0; rst mid-STALL SHALL abort the stall.

Structure
REQ-031 Shared package SHALL hold control bit indices (CTL_SALTOINCOND=9 .. CTL_ALUOP lsb=0), FSM state encoding, LOAD_STALL min/max.
REQ-032 One combinational sub-module hazard_detect SHALL compute hz; FSM, registers and counters stay in id_ex_hazard_ctrl.

Verification
REQ-033 Reset: rst=1 two cycles, Control=10'h3FF -> Controls1=0, PCWrite=0, counters 0; after release Controls1=10'h3FF one cycle later.
REQ-034 Load-use, LOAD_STALL=1: EX load (Controls1[4]=1, ex_rt=8), ID id_rs=8 -> PCWrite=0 one cycle, next Controls1=0, stall_count=1.
REQ-035 Load-use, LOAD_STALL=3: same stimulus -> PCWrite=0 exactly 3 cycles, 3 bubbles, stall_count=3; ex_rt=0 case -> no stall.
REQ-036 br_taken coincident with hz -> IFIDFlush=1, EXMEMFlush=1, PCWrite=1, Controls1=0 next, flush_count=1, stall_count unchanged.
REQ-037 Jump Control=10'h200 -> IFIDFlush=1, EXMEMFlush=0, Controls1=10'h200 next; rst during STALL -> RUN, PCWrite=1 after release.
REQ-038 Saturation: force 65536 taken branches -> flush_count holds 0xFFFF.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared constants for the ID/EX hazard controller: control-word bit map,
// FSM encoding, stall-length limits and a saturating counter helper.
package id_ex_hazard_ctrl_pkg;
   localparam int CTL_W   = 10;
   localparam int REG_W   = 5;
   localparam int CNT_W   = 16;

   localparam int CTL_SALTOINCOND = 9;
   localparam int CTL_REGDEST     = 8;
   localparam int CTL_FUENTEALU   = 7;
   localparam int CTL_MEMAREG     = 6;
   localparam int CTL_ESCRREG     = 5;
   localparam int CTL_LEERMEM     = 4;
   localparam int CTL_ESCRMEM     = 3;
   localparam int CTL_SALTOCOND   = 2;
   localparam int CTL_ALUOP_MSB   = 1;
   localparam int CTL_ALUOP_LSB   = 0;

   localparam int LOAD_STALL_MIN = 1;
   localparam int LOAD_STALL_MAX = 3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// ID-stage inputs and pipeline-control outputs of the hazard controller.
interface id_ex_hazard_ctrl_if;
   import id_ex_hazard_ctrl_pkg::*;

   logic [CTL_W-1:0] Control;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rt;
   logic             br_taken;
   logic [CTL_W-1:0] Controls1;
   logic [REG_W-1:0] ex_rt;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             IFIDFlush;
   logic             EXMEMFlush;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output Control, id_rs, id_rt, id_uses_rt, br_taken,
      input  Controls1, ex_rt, PCWrite, IFIDWrite, IFIDFlush, EXMEMFlush,
             stall_count, flush_count
   );

   modport slave (
      input  Control, id_rs, id_rt, id_uses_rt, br_taken,
      output Controls1, ex_rt, PCWrite, IFIDWrite, IFIDFlush, EXMEMFlush,
             stall_count, flush_count
   );
endinterface

// File: rtl/id_ex_hazard_ctrl_hazard_detect.sv
// Load-use hazard: a load in EX whose destination feeds a source of the
// instruction in ID. Register 0 never creates a dependency.
module hazard_detect
   import id_ex_hazard_ctrl_pkg::*;
(
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   output logic             hz
);
   assign hz = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX control register with load-use stall FSM, branch/jump flushes and
// saturating event counters.
module id_ex_hazard_ctrl
   import id_ex_hazard_ctrl_pkg::*;
#(
   parameter int LOAD_STALL = 1
) (
   input logic                clk,
   input logic                rst,
   id_ex_hazard_ctrl_if.slave bus
);
   // First cycle of a hazard is spent in RUN, so STALL covers the remainder.
   localparam logic [1:0] CNT_INIT = (LOAD_STALL >= 2) ? 2'(LOAD_STALL - 2) : 2'd0;

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [CTL_W-1:0] ctl_q, ctl_d;
   logic [REG_W-1:0] rt_q, rt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hz, stall;
   logic             pc_wr, ifid_wr, ifid_fl, exmem_fl;

   hazard_detect u_hazard_detect (
      .ex_mem_read (ctl_q[CTL_LEERMEM]),
      .ex_rt       (rt_q),
      .id_rs       (bus.id_rs),
      .id_rt       (bus.id_rt),
      .id_uses_rt  (bus.id_uses_rt),
      .hz          (hz)
   );

   assign stall = (state_q == ST_STALL) || ((state_q == ST_RUN) && hz);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ctl_d       = bus.Control;
      rt_d        = bus.id_rt;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pc_wr       = 1'b1;
      ifid_wr     = 1'b1;
      ifid_fl     = 1'b0;
      exmem_fl    = 1'b0;
      if (rst) begin
         pc_wr   = 1'b0;
         ifid_wr = 1'b0;
      end else if (bus.br_taken) begin
         ifid_fl     = 1'b1;
         exmem_fl    = 1'b1;
         ctl_d       = '0;
         rt_d        = '0;
         state_d     = ST_RUN;
         cnt_d       = 2'd0;
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (stall) begin
         pc_wr       = 1'b0;
         ifid_wr     = 1'b0;
         ctl_d       = '0;
         rt_d        = '0;
         stall_cnt_d = sat_inc(stall_cnt_q);
         if (state_q == ST_RUN) begin
            if (LOAD_STALL > 1) begin
               state_d = ST_STALL;
               cnt_d   = CNT_INIT;
            end
         end else if (cnt_q == 2'd0) begin
            state_d = ST_RUN;
         end else begin
            cnt_d = cnt_q - 2'd1;
         end
      end else if (bus.Control[CTL_SALTOINCOND]) begin
         ifid_fl = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= 2'd0;
         ctl_q       <= '0;
         rt_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ctl_q       <= ctl_d;
         rt_q        <= rt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.Controls1   = ctl_q;
   assign bus.ex_rt       = rt_q;
   assign bus.PCWrite     = pc_wr;
   assign bus.IFIDWrite   = ifid_wr;
   assign bus.IFIDFlush   = ifid_fl;
   assign bus.EXMEMFlush  = exmem_fl;
   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Two controllers (stall length 1 and 3) share one random/directed input
// stream and are compared every cycle against a remaining-stall-cycles model.
module tb_id_ex_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] i_ctl = '0;
   logic [4:0] i_rs = '0, i_rt = '0;
   logic       i_uses = 1'b0, i_br = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_hazard_ctrl_if if0();
   id_ex_hazard_ctrl_if if1();

   assign if0.Control = i_ctl;  assign if1.Control = i_ctl;
   assign if0.id_rs = i_rs;     assign if1.id_rs = i_rs;
   assign if0.id_rt = i_rt;     assign if1.id_rt = i_rt;
   assign if0.id_uses_rt = i_uses; assign if1.id_uses_rt = i_uses;
   assign if0.br_taken = i_br;  assign if1.br_taken = i_br;

   id_ex_hazard_ctrl #(.LOAD_STALL(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   id_ex_hazard_ctrl #(.LOAD_STALL(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Model: per DUT, how many stall cycles remain after the current one.
   int         ls[2] = '{1, 3};
   int         rem[2];
   logic [9:0] m_c1[2];
   logic [4:0] m_rt[2];
   int         m_sc[2], m_fc[2];
   bit         mvalid = 0;

   function automatic bit m_stall(input int k);
      bit dep;
      dep = m_c1[k][4] && (m_rt[k] != 0) &&
            ((m_rt[k] == i_rs) || (i_uses && (m_rt[k] == i_rt)));
      return (rem[k] > 0) || dep;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            rem[k] = 0; m_c1[k] = '0; m_rt[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
         end else if (i_br) begin
            rem[k] = 0; m_c1[k] = '0; m_rt[k] = '0;
            m_fc[k] = (m_fc[k] < 65535) ? m_fc[k] + 1 : 65535;
         end else if (m_stall(k)) begin
            rem[k] = (rem[k] > 0) ? rem[k] - 1 : ls[k] - 1;
            m_c1[k] = '0; m_rt[k] = '0;
            m_sc[k] = (m_sc[k] < 65535) ? m_sc[k] + 1 : 65535;
         end else begin
            m_c1[k] = i_ctl; m_rt[k] = i_rt;
         end
      end
      if (rst) mvalid = 1;
   end

   task automatic cmp(input int k, input logic [9:0] c1, input logic [4:0] ert,
                      input logic [3:0] ctl4, input logic [15:0] sc, input logic [15:0] fc);
      logic [3:0] e;
      if (rst)              e = 4'b0000;
      else if (i_br)        e = 4'b1111;
      else if (m_stall(k))  e = 4'b0000;
      else if (i_ctl[9])    e = 4'b1110;
      else                  e = 4'b1100;
      chk($sformatf("d%0d_pcw_ifw_iff_emf", k), 32'(ctl4), 32'(e));
      chk($sformatf("d%0d_Controls1", k), 32'(c1), 32'(m_c1[k]));
      chk($sformatf("d%0d_ex_rt", k), 32'(ert), 32'(m_rt[k]));
      chk($sformatf("d%0d_stall_count", k), 32'(sc), 32'(m_sc[k]));
      chk($sformatf("d%0d_flush_count", k), 32'(fc), 32'(m_fc[k]));
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         cmp(0, if0.Controls1, if0.ex_rt,
             {if0.PCWrite, if0.IFIDWrite, if0.IFIDFlush, if0.EXMEMFlush},
             if0.stall_count, if0.flush_count);
         cmp(1, if1.Controls1, if1.ex_rt,
             {if1.PCWrite, if1.IFIDWrite, if1.IFIDFlush, if1.EXMEMFlush},
             if1.stall_count, if1.flush_count);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lo0, lo1;
      // Reset with an all-ones decoder word in ID
      i_ctl = 10'h3FF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_Controls1", 32'(if0.Controls1), 32'h0);
      chk("rst_PCWrite", 32'(if1.PCWrite), 32'h0);
      chk("rst_stall_count", 32'(if1.stall_count), 32'h0);
      chk("rst_flush_count", 32'(if0.flush_count), 32'h0);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("rel_Controls1_hold", 32'(if0.Controls1), 32'h0);
      tick();
      @(negedge clk);
      chk("rel_Controls1_d0", 32'(if0.Controls1), 32'h3FF);
      chk("rel_Controls1_d1", 32'(if1.Controls1), 32'h3FF);

      // Load into r8 in EX, dependent rs in ID
      tick(); i_ctl = 10'h010; i_rt = 5'd8; i_rs = 5'd0;
      tick(); i_ctl = 10'h000; i_rt = 5'd0; i_rs = 5'd8;
      lo0 = 0; lo1 = 0;
      repeat (5) begin
         @(negedge clk);
         lo0 += int'(!if0.PCWrite);
         lo1 += int'(!if1.PCWrite);
      end
      chk("ls1_stall_cycles", 32'(lo0), 32'd1);
      chk("ls3_stall_cycles", 32'(lo1), 32'd3);
      chk("ls1_stall_count", 32'(if0.stall_count), 32'd1);
      chk("ls3_stall_count", 32'(if1.stall_count), 32'd3);

      // Load into r0 never stalls
      tick(); i_ctl = 10'h010; i_rt = 5'd0; i_rs = 5'd0;
      tick(); i_ctl = 10'h000;
      @(negedge clk);
      chk("r0_no_stall_pcw", 32'(if1.PCWrite), 32'd1);

      // Taken branch coincident with a load-use hazard
      tick(); i_ctl = 10'h010; i_rt = 5'd8;
      tick(); i_ctl = 10'h000; i_rs = 5'd8; i_br = 1'b1;
      @(negedge clk);
      chk("br_flushes_pcw", 32'({if1.IFIDFlush, if1.EXMEMFlush, if1.PCWrite}), 32'b111);
      tick(); i_br = 1'b0; i_rs = 5'd0; i_ctl = 10'h200;
      @(negedge clk);
      chk("br_Controls1", 32'(if1.Controls1), 32'h0);
      chk("br_flush_count", 32'(if1.flush_count), 32'd1);
      chk("br_stall_count", 32'(if1.stall_count), 32'd3);
      // Jump issued in the same cycle
      chk("jmp_flushes", 32'({if1.IFIDFlush, if1.EXMEMFlush}), 32'b10);
      tick(); i_ctl = 10'h010; i_rt = 5'd9;
      @(negedge clk);
      chk("jmp_Controls1", 32'(if1.Controls1), 32'h200);

      // Reset in the middle of a 3-cycle stall
      tick(); i_ctl = 10'h000; i_rt = 5'd0; i_rs = 5'd9;
      @(negedge clk);
      chk("pre_rst_stall", 32'(if1.PCWrite), 32'd0);
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("post_rst_pcw", 32'(if1.PCWrite), 32'd1);

      // Random traffic, small register range to make dependencies common
      repeat (3000) begin
         tick();
         rst    = ($urandom_range(0, 99) == 0);
         i_br   = ($urandom_range(0, 9) == 0);
         i_ctl  = 10'($urandom);
         if ($urandom_range(0, 1) == 1) i_ctl[4] = 1'b1;
         if ($urandom_range(0, 3) != 0) i_ctl[9] = 1'b0;
         i_rs   = 5'($urandom_range(0, 3));
         i_rt   = 5'($urandom_range(0, 3));
         i_uses = 1'($urandom);
      end

      // Saturate the flush counter
      tick(); rst = 1'b0; i_br = 1'b1; i_ctl = '0;
      repeat (65540) tick();
      @(negedge clk);
      chk("flush_sat_d0", 32'(if0.flush_count), 32'hFFFF);
      chk("flush_sat_d1", 32'(if1.flush_count), 32'hFFFF);
      tick(); i_br = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
